// File: rtl/vc_mem_msgs_pkg.sv
// Shared vc memory message types: 4-byte request/response structs and type codes.
package vc_mem_msgs_pkg;

    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_READ       = 3'd0;
    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_WRITE      = 3'd1;
    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_WRITE_INIT = 3'd2;

    localparam logic [2:0] VC_MEM_RESP_MSG_TYPE_READ       = 3'd0;
    localparam logic [2:0] VC_MEM_RESP_MSG_TYPE_WRITE      = 3'd1;
    localparam logic [2:0] VC_MEM_RESP_MSG_TYPE_WRITE_INIT = 3'd2;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

// File: rtl/test_mem_responder_array.sv
// Word array for the memory responder: byte-enabled request write port,
// full-word init write port (takes priority) and a combinational read.
module test_mem_responder_array #(
    parameter int unsigned p_mem_nwords = 16384
) (
    input  logic                             clk,
    input  logic                             wr_en,
    input  logic [$clog2(p_mem_nwords)-1:0]  wr_idx,
    input  logic [3:0]                       wr_be,
    input  logic [31:0]                      wr_data,
    input  logic                             init_en,
    input  logic [$clog2(p_mem_nwords)-1:0]  init_idx,
    input  logic [31:0]                      init_data,
    input  logic [$clog2(p_mem_nwords)-1:0]  rd_idx,
    output logic [31:0]                      rd_data
);

    logic [31:0] mem [p_mem_nwords];

    // Init write is issued last so it overrides a same-word request write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (init_en) begin
            mem[init_idx] <= init_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/test_mem_responder.sv
// Single-port val/rdy memory responder with programmable response latency
// and a side init port for loading memory images.
module test_mem_responder
    import vc_mem_msgs_pkg::*;
#(
    parameter int unsigned p_mem_nwords = 16384,
    parameter int unsigned p_latency    = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reqstream_val,
    output logic         reqstream_rdy,
    input  mem_req_4B_t  reqstream_msg,
    output logic         respstream_val,
    input  logic         respstream_rdy,
    output mem_resp_4B_t respstream_msg,
    input  logic         mem_init_wen,
    input  logic [31:0]  mem_init_addr,
    input  logic [31:0]  mem_init_data
);

    localparam int unsigned W       = $clog2(p_mem_nwords);
    localparam logic [3:0]  LATENCY = 4'(p_latency);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_RESP
    } state_e;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    mem_resp_4B_t resp_q, resp_d;

    logic         req_fire;
    logic         resp_fire;
    logic         is_write;
    logic [1:0]   byte_off;
    logic [3:0]   lane_mask;
    logic [3:0]   wr_be;
    logic [31:0]  data_mask;
    logic [31:0]  wr_data;
    logic [31:0]  rd_word;
    logic [31:0]  rd_data;
    logic [W-1:0] req_idx;
    logic [W-1:0] init_idx;
    logic         unused_addr_bits;

    assign reqstream_rdy  = !reset &&
                            ((state_q == ST_IDLE) || ((state_q == ST_RESP) && respstream_rdy));
    assign respstream_val = (state_q == ST_RESP);
    assign respstream_msg = resp_q;
    assign req_fire       = reqstream_val && reqstream_rdy;
    assign resp_fire      = respstream_val && respstream_rdy;

    // Upper address bits alias; init addresses are word-granular.
    assign req_idx          = reqstream_msg.addr[2 +: W];
    assign init_idx         = mem_init_addr[2 +: W];
    assign unused_addr_bits = ^{reqstream_msg.addr[31:2+W], mem_init_addr[31:2+W],
                                mem_init_addr[1:0]};

    always_comb begin
        byte_off = (reqstream_msg.len == 2'd0) ? 2'd0 : reqstream_msg.addr[1:0];
        case (reqstream_msg.len)
            2'd1:    begin lane_mask = 4'b0001; data_mask = 32'h0000_00ff; end
            2'd2:    begin lane_mask = 4'b0011; data_mask = 32'h0000_ffff; end
            2'd3:    begin lane_mask = 4'b0111; data_mask = 32'h00ff_ffff; end
            default: begin lane_mask = 4'b1111; data_mask = 32'hffff_ffff; end
        endcase
        // Shifts drop lanes past byte 3, so partial accesses never wrap.
        wr_be    = lane_mask << byte_off;
        wr_data  = reqstream_msg.data << {byte_off, 3'b000};
        rd_data  = (rd_word >> {byte_off, 3'b000}) & data_mask;
        is_write = (reqstream_msg.type_ == VC_MEM_REQ_MSG_TYPE_WRITE) ||
                   (reqstream_msg.type_ == VC_MEM_REQ_MSG_TYPE_WRITE_INIT);
    end

    test_mem_responder_array #(
        .p_mem_nwords(p_mem_nwords)
    ) u_array (
        .clk       (clk),
        .wr_en     (req_fire && is_write),
        .wr_idx    (req_idx),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .init_en   (mem_init_wen),
        .init_idx  (init_idx),
        .init_data (mem_init_data),
        .rd_idx    (req_idx),
        .rd_data   (rd_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;

        case (state_q)
            ST_IDLE: ;
            ST_DELAY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (req_fire) begin
            cnt_d         = LATENCY;
            state_d       = (LATENCY == 4'd0) ? ST_RESP : ST_DELAY;
            resp_d.type_  = reqstream_msg.type_;
            resp_d.opaque = reqstream_msg.opaque;
            resp_d.test   = 2'd0;
            resp_d.len    = reqstream_msg.len;
            resp_d.data   = is_write ? '0 : rd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

endmodule

// File: tb/tb_test_mem_responder.sv
// Scoreboard bench for test_mem_responder: zero-latency and latency-3 instances.
module tb_test_mem_responder;
    import vc_mem_msgs_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         req_val0, req_rdy0, resp_val0, resp_rdy0;
    mem_req_4B_t  req_msg0;
    mem_resp_4B_t resp_msg0;
    logic         req_val3, req_rdy3, resp_val3, resp_rdy3;
    mem_req_4B_t  req_msg3;
    mem_resp_4B_t resp_msg3;
    logic         init_wen;
    logic [31:0]  init_addr, init_data;

    int tests_run = 0;
    int tests_failed = 0;

    mem_resp_4B_t exp_q[$];
    logic [31:0]  model [16384];

    test_mem_responder #(.p_mem_nwords(16384), .p_latency(0)) dut0 (
        .clk(clk), .reset(reset),
        .reqstream_val(req_val0), .reqstream_rdy(req_rdy0), .reqstream_msg(req_msg0),
        .respstream_val(resp_val0), .respstream_rdy(resp_rdy0), .respstream_msg(resp_msg0),
        .mem_init_wen(init_wen), .mem_init_addr(init_addr), .mem_init_data(init_data)
    );

    test_mem_responder #(.p_mem_nwords(16384), .p_latency(3)) dut3 (
        .clk(clk), .reset(reset),
        .reqstream_val(req_val3), .reqstream_rdy(req_rdy3), .reqstream_msg(req_msg3),
        .respstream_val(resp_val3), .respstream_rdy(resp_rdy3), .respstream_msg(resp_msg3),
        .mem_init_wen(init_wen), .mem_init_addr(init_addr), .mem_init_data(init_data)
    );

    function automatic mem_req_4B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                           input logic [31:0] a, input logic [1:0] l,
                                           input logic [31:0] d);
        mem_req_4B_t r;
        r.type_ = t; r.opaque = op; r.addr = a; r.len = l; r.data = d;
        return r;
    endfunction

    // Reference model: byte-by-byte access on the bench's own copy of memory.
    function automatic mem_resp_4B_t model_access(input mem_req_4B_t r);
        mem_resp_4B_t e;
        int unsigned  idx, n, off;
        logic [31:0]  word, res;
        logic         wr;
        idx  = (r.addr >> 2) % 16384;
        n    = (r.len == 2'd0) ? 4 : int'(r.len);
        off  = (r.len == 2'd0) ? 0 : int'(r.addr[1:0]);
        wr   = (r.type_ == VC_MEM_REQ_MSG_TYPE_WRITE) || (r.type_ == VC_MEM_REQ_MSG_TYPE_WRITE_INIT);
        word = model[idx];
        res  = 32'h0;
        for (int unsigned i = 0; i < n; i++) begin
            if (off + i < 4) begin
                if (wr) word[8*(off+i) +: 8] = r.data[8*i +: 8];
                else    res[8*i +: 8] = word[8*(off+i) +: 8];
            end
        end
        if (wr) model[idx] = word;
        e.type_ = r.type_; e.opaque = r.opaque; e.test = 2'd0; e.len = r.len;
        e.data  = wr ? 32'h0 : res;
        return e;
    endfunction

    task automatic init_write(input logic [31:0] a, input logic [31:0] d);
        init_wen = 1'b1; init_addr = a; init_data = d;
        @(posedge clk);
        model[(a >> 2) % 16384] = d;
        @(negedge clk);
        init_wen = 1'b0;
    endtask

    task automatic send0(input mem_req_4B_t r, input logic do_init,
                         input logic [31:0] ia, input logic [31:0] id);
        int c;
        req_msg0 = r; req_val0 = 1'b1;
        init_wen = do_init; init_addr = ia; init_data = id;
        #1;
        c = 0;
        while (!req_rdy0 && c < 50) begin
            @(negedge clk); #1; c++;
        end
        if (!req_rdy0) begin
            tests_run++; tests_failed++;
            $display("FAIL send0_timeout: rdy=%b required 1", req_rdy0);
            req_val0 = 1'b0; init_wen = 1'b0;
            return;
        end
        exp_q.push_back(model_access(r));
        if (do_init) model[(ia >> 2) % 16384] = id;
        @(posedge clk);
        @(negedge clk);
        req_val0 = 1'b0; init_wen = 1'b0;
    endtask

    task automatic recv0(input string name);
        mem_resp_4B_t e;
        int c;
        resp_rdy0 = 1'b1;
        c = 0;
        while (!resp_val0 && c < 50) begin
            @(negedge clk); c++;
        end
        tests_run++;
        if (!resp_val0 || exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s_timeout: val=%b queued=%0d required val 1 and a queued entry",
                     name, resp_val0, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (resp_msg0 !== e) begin
                tests_failed++;
                $display("FAIL %s: got %h required %h", name, resp_msg0, e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        resp_rdy0 = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({req_rdy0, resp_val0, req_rdy3, resp_val3} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_handshake: got %b required 0000",
                     {req_rdy0, resp_val0, req_rdy3, resp_val3});
        end
        tests_run++;
        if (resp_msg0 !== '0) begin
            tests_failed++;
            $display("FAIL reset_msg: got %h required 0", resp_msg0);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({req_rdy0, req_rdy3} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_release_rdy: got %b required 11", {req_rdy0, req_rdy3});
        end
        @(negedge clk);
    endtask

    task automatic test_read_basic;
        init_write(32'h200, 32'h0010_8863);
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h5a, 32'h200, 2'd0, 32'h0), 1'b0, 0, 0);
        tests_run++;
        if (resp_val0 !== 1'b1 || resp_msg0.data !== 32'h0010_8863 || resp_msg0.test !== 2'd0) begin
            tests_failed++;
            $display("FAIL read_basic_lat0: got val=%b data=%h test=%0d required val=1 data=00108863 test=0",
                     resp_val0, resp_msg0.data, resp_msg0.test);
        end
        recv0("read_basic");
    endtask

    task automatic test_byte_write;
        init_write(32'h1000, 32'h1122_3344);
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_WRITE, 8'h01, 32'h1002, 2'd2, 32'h0000_beef), 1'b0, 0, 0);
        recv0("write_len2");
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h02, 32'h1000, 2'd0, 32'h0), 1'b0, 0, 0);
        tests_run++;
        if (resp_msg0.data !== 32'hbeef_3344) begin
            tests_failed++;
            $display("FAIL byte_write_word: got %h required beef3344", resp_msg0.data);
        end
        recv0("read_after_write");
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h03, 32'h1003, 2'd1, 32'h0), 1'b0, 0, 0);
        tests_run++;
        if (resp_msg0.data !== 32'h0000_00be) begin
            tests_failed++;
            $display("FAIL byte_read_len1: got %h required 000000be", resp_msg0.data);
        end
        recv0("read_len1_off3");
        // len 3 at offset 3 writes only byte 3; len 3 reads drop lanes past byte 3
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_WRITE_INIT, 8'h04, 32'h1003, 2'd3, 32'h00aa_bbcc), 1'b0, 0, 0);
        recv0("write_init_len3_off3");
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h05, 32'h1001, 2'd3, 32'h0), 1'b0, 0, 0);
        recv0("read_len3_off1");
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h06, 32'h1002, 2'd3, 32'h0), 1'b0, 0, 0);
        recv0("read_len3_off2");
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h07, 32'h1003, 2'd0, 32'h0), 1'b0, 0, 0);
        recv0("read_len0_ignores_off");
    endtask

    task automatic test_alias;
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_WRITE, 8'h10, 32'h0001_0004, 2'd0, 32'ha5a5_5a5a), 1'b0, 0, 0);
        recv0("alias_write");
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h11, 32'h4, 2'd0, 32'h0), 1'b0, 0, 0);
        tests_run++;
        if (resp_msg0.data !== 32'ha5a5_5a5a) begin
            tests_failed++;
            $display("FAIL alias_read: got %h required a5a55a5a", resp_msg0.data);
        end
        recv0("alias_read_sb");
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_WRITE, 8'h12, 32'h40, 2'd0, 32'h1234_5678), 1'b1,
              32'h40, 32'hdead_beef);
        recv0("init_vs_write");
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h13, 32'h40, 2'd0, 32'h0), 1'b0, 0, 0);
        tests_run++;
        if (resp_msg0.data !== 32'hdead_beef) begin
            tests_failed++;
            $display("FAIL init_wins: got %h required deadbeef", resp_msg0.data);
        end
        recv0("init_wins_sb");
        init_write(32'h44, 32'h1111_1111);
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h14, 32'h44, 2'd0, 32'h0), 1'b1,
              32'h44, 32'h2222_2222);
        tests_run++;
        if (resp_msg0.data !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL read_during_init: got %h required 11111111", resp_msg0.data);
        end
        recv0("read_during_init_sb");
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h15, 32'h44, 2'd0, 32'h0), 1'b0, 0, 0);
        recv0("read_after_init");
    endtask

    task automatic test_backpressure;
        mem_resp_4B_t first;
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h77, 32'h200, 2'd0, 32'h0), 1'b0, 0, 0);
        resp_rdy0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (resp_val0 !== 1'b1 || req_rdy0 !== 1'b0 || exp_q.size() == 0 || resp_msg0 !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL backpressure_hold%0d: got val=%b rdy=%b msg=%h required val=1 rdy=0 msg=%h",
                         i, resp_val0, req_rdy0, resp_msg0, (exp_q.size() != 0) ? exp_q[0] : '0);
            end
            @(negedge clk);
        end
        resp_rdy0 = 1'b1;
        req_val0  = 1'b1;
        req_msg0  = mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h78, 32'h1000, 2'd0, 32'h0);
        #1;
        tests_run++;
        if (req_rdy0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_release_rdy: got %b required 1", req_rdy0);
        end
        first = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        tests_run++;
        if (resp_msg0 !== first) begin
            tests_failed++;
            $display("FAIL backpressure_msg: got %h required %h", resp_msg0, first);
        end
        if (req_rdy0) exp_q.push_back(model_access(req_msg0));
        @(posedge clk);
        @(negedge clk);
        req_val0  = 1'b0;
        resp_rdy0 = 1'b0;
        recv0("back_to_back_second");
    endtask

    task automatic test_back_to_back;
        mem_req_4B_t reqs[6];
        int unsigned i, cycles, first_fire, last_fire;
        logic fired;
        reqs[0] = mk_req(VC_MEM_REQ_MSG_TYPE_READ,  8'h20, 32'h200,  2'd0, 32'h0);
        reqs[1] = mk_req(VC_MEM_REQ_MSG_TYPE_WRITE, 8'h21, 32'h1001, 2'd1, 32'h0000_0099);
        reqs[2] = mk_req(VC_MEM_REQ_MSG_TYPE_READ,  8'h22, 32'h1000, 2'd0, 32'h0);
        reqs[3] = mk_req(VC_MEM_REQ_MSG_TYPE_READ,  8'h23, 32'h4,    2'd2, 32'h0);
        reqs[4] = mk_req(VC_MEM_REQ_MSG_TYPE_READ,  8'h24, 32'h202,  2'd2, 32'h0);
        reqs[5] = mk_req(VC_MEM_REQ_MSG_TYPE_READ,  8'h25, 32'h44,   2'd1, 32'h0);
        i = 0; cycles = 0; first_fire = 0; last_fire = 0;
        resp_rdy0 = 1'b1;
        while ((i < 6 || exp_q.size() != 0) && cycles < 100) begin
            if (resp_val0) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_unexpected_resp: got %h required none", resp_msg0);
                end else if (resp_msg0 !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL b2b_resp: got %h required %h", resp_msg0, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            req_val0 = (i < 6);
            if (i < 6) req_msg0 = reqs[i];
            #1;
            fired = req_val0 && req_rdy0;
            if (fired) begin
                exp_q.push_back(model_access(req_msg0));
                if (i == 0) first_fire = cycles;
                last_fire = cycles;
            end
            @(posedge clk);
            if (fired) i++;
            cycles++;
            @(negedge clk);
        end
        req_val0  = 1'b0;
        resp_rdy0 = 1'b0;
        tests_run++;
        if (i != 6 || last_fire - first_fire != 5) begin
            tests_failed++;
            $display("FAIL b2b_throughput: got %0d accepted over %0d cycles required 6 over 5",
                     i, last_fire - first_fire);
        end
    endtask

    task automatic test_latency;
        mem_resp_4B_t e;
        e.type_ = VC_MEM_RESP_MSG_TYPE_READ; e.opaque = 8'h33; e.test = 2'd0; e.len = 2'd0;
        e.data  = 32'h0010_8863;
        req_val3 = 1'b1;
        req_msg3 = mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h33, 32'h200, 2'd0, 32'h0);
        #1;
        tests_run++;
        if (req_rdy3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat3_accept: got rdy=%b required 1", req_rdy3);
        end
        @(posedge clk);
        @(negedge clk);
        req_val3 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tests_run++;
            if (resp_val3 !== 1'b0 || req_rdy3 !== 1'b0) begin
                tests_failed++;
                $display("FAIL lat3_cycle%0d: got val=%b rdy=%b required val=0 rdy=0",
                         k, resp_val3, req_rdy3);
            end
            @(negedge clk);
        end
        tests_run++;
        if (resp_val3 !== 1'b1 || resp_msg3 !== e) begin
            tests_failed++;
            $display("FAIL lat3_resp: got val=%b msg=%h required val=1 msg=%h", resp_val3, resp_msg3, e);
        end
        resp_rdy3 = 1'b1;
        @(negedge clk);
        resp_rdy3 = 1'b0;
        tests_run++;
        if (resp_val3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat3_drain: got val=%b required 0", resp_val3);
        end
    endtask

    task automatic test_reset_mid;
        int c;
        send0(mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h40, 32'h200, 2'd0, 32'h0), 1'b0, 0, 0);
        req_val3 = 1'b1;
        req_msg3 = mk_req(VC_MEM_REQ_MSG_TYPE_WRITE, 8'h44, 32'h300, 2'd0, 32'hcafe_f00d);
        @(posedge clk);
        @(negedge clk);
        req_val3 = 1'b0;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({resp_val0, resp_val3, req_rdy0, req_rdy3} !== 4'b0000 || resp_msg0 !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got vals=%b%b rdys=%b%b msg=%h required 0000 msg 0",
                     resp_val0, resp_val3, req_rdy0, req_rdy3, resp_msg0);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if ({req_rdy0, req_rdy3} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_mid_idle: got rdy=%b required 11", {req_rdy0, req_rdy3});
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if ({resp_val0, resp_val3} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_mid_no_stale: got val=%b required 00", {resp_val0, resp_val3});
        end
        req_val3 = 1'b1;
        req_msg3 = mk_req(VC_MEM_REQ_MSG_TYPE_READ, 8'h45, 32'h300, 2'd0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_val3 = 1'b0;
        c = 0;
        while (!resp_val3 && c < 20) begin
            @(negedge clk); c++;
        end
        tests_run++;
        if (resp_val3 !== 1'b1 || resp_msg3.data !== 32'hcafe_f00d) begin
            tests_failed++;
            $display("FAIL reset_mid_write_kept: got val=%b data=%h required val=1 data=cafef00d",
                     resp_val3, resp_msg3.data);
        end
        resp_rdy3 = 1'b1;
        @(negedge clk);
        resp_rdy3 = 1'b0;
    endtask

    initial begin
        req_val0 = 1'b0; resp_rdy0 = 1'b0; req_msg0 = '0;
        req_val3 = 1'b0; resp_rdy3 = 1'b0; req_msg3 = '0;
        init_wen = 1'b0; init_addr = '0; init_data = '0;
        test_reset();
        test_read_basic();
        test_byte_write();
        test_alias();
        test_backpressure();
        test_back_to_back();
        test_latency();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/test_mem_responder.md
# test_mem_responder

Single-port memory responder: the memory-side end of the 4-byte val/rdy memory request/response interface the processor drives on its imem and dmem ports. It accepts `mem_req_4B_t` requests, performs a read or byte-masked write on an internal word array after a programmable latency, and returns a `mem_resp_4B_t`. It is used as the instruction and data memory behind the processor in test harnesses. A side init port lets benches load programs.

## Interface
- `p_mem_nwords`, default 16384: word-array depth; power of two; index width `$clog2(p_mem_nwords)`.
- `p_latency`, default 0: extra cycles between request acceptance and response valid; legal range 0..15.

- `clk` in 1: clock.
- `reset` in 1: active-high asynchronous reset; this is the only clock/reset pair.
- `reqstream_val` in 1: request valid.
- `reqstream_rdy` out 1: request ready.
- `reqstream_msg` in `mem_req_4B_t`: type_, opaque, addr, len, data.
- `respstream_val` out 1: response valid.
- `respstream_rdy` in 1: response ready.
- `respstream_msg` out `mem_resp_4B_t`: type_, opaque, test, len, data.
- `mem_init_wen` in 1: init word write enable.
- `mem_init_addr` in 32: init byte address; bits [1:0] ignored.
- `mem_init_data` in 32: init word.

## Operation
- FSM states: IDLE, DELAY, RESP. Fire means val && rdy.
- `reqstream_rdy` = (IDLE) || (RESP && `respstream_rdy`). This is a combinational path from `respstream_rdy`.
- Request fire: capture type_, opaque, len. Perform the access at that edge. Load a 4-bit counter with `p_latency`. Next state is RESP if `p_latency`==0, otherwise DELAY.
- DELAY: the counter decrements each cycle. When the counter reaches 1, go to RESP.
- RESP: `respstream_val`=1 and `respstream_msg` is held stable until fire. On fire, go to IDLE, or reload directly if a new request fires in the same cycle.
- Word index = addr[2+W-1:2], with W = `$clog2(p_mem_nwords)`. Higher address bits are ignored, so addresses alias modulo the array size.
- len 0 means 4 bytes and ignores addr[1:0]. len 1, 2, 3 means that many bytes starting at byte offset addr[1:0].
  - Lanes beyond byte 3 are dropped. There is no wrap into the next word.
- READ (type 0): data = selected bytes shifted to bit 0 and zero-extended, captured at acceptance.
- WRITE (type 1): byte-masked write of data[8*len-1:0] at offset addr[1:0]. The response data is 0.
- WRITE_INIT (type 2): same as WRITE.
- Response fields: type_ echoes the request, opaque echoes, len echoes, test = 0.
- Init port: when `mem_init_wen`=1, the full word is written at the edge, independent of FSM state.
  - If an init write and a request write target the same word in the same cycle, the init port wins.
  - A read accepted in the same cycle as an init write to the same word returns the old data.
- Memory contents are not affected by reset.

## Timing
- Reset values: state IDLE, counter 0, `respstream_val` 0, `respstream_msg` 0.
- `reqstream_rdy` is 0 while `reset`=1 and goes to 1 in the first cycle after deassertion.
- Latency: a request firing in cycle N produces `respstream_val` high from cycle N+1+`p_latency`.
- Throughput with `respstream_rdy` held at 1: one transaction per 1+`p_latency` cycles.
- Backpressure: `respstream_val` stays high indefinitely. No further request is accepted until the response fires.
- Reset mid-transaction: the pending response is discarded and the state returns to IDLE. A write already committed at acceptance remains in memory.
- `reqstream_val` with `reqstream_rdy`=0 has no effect. The requester must hold the message.

## Structure
- `mem_req_4B_t`, `mem_resp_4B_t` and the `VC_MEM_REQ/RESP_MSG_TYPE_*` constants come from the shared vc mem-msgs package. No new package types are added.
- The FSM state enum is local to the module.
- Sub-module `test_mem_responder_array`: the word array, with one byte-enabled write port, an init write port, and a combinational read.
- The top level holds the FSM, the counter, the byte-lane shift/mask logic and the response register.

## Test plan
- Init word 0x200 = 0x00108863; READ addr 0x200 len 0 with `p_latency`=0. Expected: resp valid the next cycle, data 0x00108863, opaque echoed, test 0.
- WRITE addr 0x1002 len 2 data 0xBEEF over an init value of 0x11223344, then READ len 0. Expected: 0xBEEF3344. A READ of addr 0x1003 len 1 returns 0x000000BE.
- `p_latency`=3: a request fires at cycle 10. Expected: `respstream_val` rises at cycle 14, and `reqstream_rdy` is 0 during cycles 11–13.
- Hold `respstream_rdy`=0 for 5 cycles. Expected: msg stable and val high throughout. When rdy is raised, a back-to-back request is accepted in the same cycle.
- Aliasing: with `p_mem_nwords`=16384, WRITE addr 0x10004 then READ addr 0x4. Expected: the written data. A simultaneous init write and request write to the same word leaves the init data.
- Assert `reset` in the DELAY state. Expected: `respstream_val` 0 immediately and state IDLE. The previously accepted write is still visible to a later READ.
